// File: rtl/router_pkg.sv
// Shared router definitions: byte width, port address codes and the FSM state
// encoding used by router_fsm and the datapath register stage.
package router_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] ADDR_P0      = 2'd0;
    localparam logic [1:0] ADDR_P1      = 2'd1;
    localparam logic [1:0] ADDR_P2      = 2'd2;
    localparam logic [1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        ST_DECODE_ADDRESS   = 3'd0,
        ST_LOAD_FIRST_DATA  = 3'd1,
        ST_LOAD_DATA        = 3'd2,
        ST_WAIT_TILL_EMPTY  = 3'd3,
        ST_FIFO_FULL        = 3'd4,
        ST_LOAD_AFTER_FULL  = 3'd5,
        ST_LOAD_PARITY      = 3'd6,
        ST_CHECK_PARITY_ERR = 3'd7
    } router_state_e;

    function automatic logic addr_is_valid(input logic [1:0] addr);
        return (addr == ADDR_P0) || (addr == ADDR_P1) || (addr == ADDR_P2);
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR of header and payload bytes for one packet, compared against the
// parity byte sent by the source.
module router_parity_acc #(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              hdr_load,
    input  logic [DATA_W-1:0] hdr,
    input  logic              data_load,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] pkt_parity,
    output logic              mismatch
);
    import router_pkg::*;

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else begin
            if (hdr_load)  acc_d = acc_d ^ hdr;
            if (data_load) acc_d = acc_d ^ data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign mismatch = (acc_q != pkt_parity);

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, payload re-timing, full-hold
// byte and packet flags. Parity checking is built only with ROUTER_REG_PARITY_CHECK_EN.
module router_reg #(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              packet_valid,
    input  logic [DATA_W-1:0] datain,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_packet_valid,
    output logic              err
);
    import router_pkg::*;

    logic [DATA_W-1:0] header_q, header_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              parity_done_q, parity_done_d;
    logic              low_packet_valid_q, low_packet_valid_d;
    logic              pd_set;

    // full_state only parks the datapath; nothing here reacts to it.
    logic unused_full_state;
    assign unused_full_state = full_state;

    always_comb begin
        header_d           = header_q;
        hold_d             = hold_q;
        dout_d             = dout_q;
        parity_done_d      = parity_done_q;
        low_packet_valid_d = low_packet_valid_q;

        if (detect_add && packet_valid && addr_is_valid(datain[1:0]))
            header_d = datain;

        // The parity byte takes the same path as payload when the FIFO has room.
        if (lfd_state)                   dout_d = header_q;
        else if (ld_state && !fifo_full) dout_d = datain;
        else if (ld_state && fifo_full)  hold_d = datain;
        else if (laf_state)              dout_d = hold_q;

        pd_set = (ld_state && !fifo_full && !packet_valid) ||
                 (laf_state && low_packet_valid_q && !parity_done_q);
        if (pd_set)          parity_done_d = 1'b1;
        else if (detect_add) parity_done_d = 1'b0;

        if (ld_state && !packet_valid) low_packet_valid_d = 1'b1;
        else if (rst_int_reg)          low_packet_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            header_q           <= '0;
            hold_q             <= '0;
            dout_q             <= '0;
            parity_done_q      <= 1'b0;
            low_packet_valid_q <= 1'b0;
        end else begin
            header_q           <= header_d;
            hold_q             <= hold_d;
            dout_q             <= dout_d;
            parity_done_q      <= parity_done_d;
            low_packet_valid_q <= low_packet_valid_d;
        end
    end

    assign dout             = dout_q;
    assign parity_done      = parity_done_q;
    assign low_packet_valid = low_packet_valid_q;

`ifdef ROUTER_REG_PARITY_CHECK_EN
    logic [DATA_W-1:0] pkt_parity_q, pkt_parity_d;
    logic              err_q, err_d;
    logic              parity_mismatch;

    router_parity_acc #(.DATA_W(DATA_W)) u_parity_acc (
        .clk        (clk),
        .reset      (reset),
        .clear      (detect_add),
        .hdr_load   (lfd_state),
        .hdr        (header_q),
        .data_load  (ld_state && packet_valid),
        .data       (datain),
        .pkt_parity (pkt_parity_q),
        .mismatch   (parity_mismatch)
    );

    // A new packet's detect_add must clear err even though parity_done is still high.
    always_comb begin
        pkt_parity_d = pkt_parity_q;
        err_d        = err_q;
        if (ld_state && !packet_valid) pkt_parity_d = datain;
        if (detect_add)                err_d = 1'b0;
        else if (parity_done_q)        err_d = parity_mismatch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_parity_q <= '0;
            err_q        <= 1'b0;
        end else begin
            pkt_parity_q <= pkt_parity_d;
            err_q        <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: each task walks one FSM strobe sequence and
// checks the registered outputs 1ns after the clock edge.
module tb_router_reg;
    import router_pkg::*;

    localparam int W = router_pkg::DATA_W;

`ifdef ROUTER_REG_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // Strobe order: {detect_add, lfd, ld, laf, full, rst_int_reg}
    localparam logic [5:0] S_IDLE = 6'b000000;
    localparam logic [5:0] S_DA   = 6'b100000;
    localparam logic [5:0] S_LFD  = 6'b010000;
    localparam logic [5:0] S_LD   = 6'b001000;
    localparam logic [5:0] S_LAF  = 6'b000100;
    localparam logic [5:0] S_FULL = 6'b000010;
    localparam logic [5:0] S_RST  = 6'b000001;

    logic         clk = 1'b0;
    logic         reset;
    logic         packet_valid;
    logic [W-1:0] datain;
    logic         fifo_full;
    logic         detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [W-1:0] dout;
    logic         parity_done, low_packet_valid, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_reg #(.DATA_W(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .packet_valid     (packet_valid),
        .datain           (datain),
        .fifo_full        (fifo_full),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .dout             (dout),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .err              (err)
    );

    // Apply one cycle of strobes and data, then land 1ns past the sampling edge.
    task automatic drive(input logic [5:0] st, input logic pv, input logic ff,
                         input logic [W-1:0] d);
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
        packet_valid = pv;
        fifo_full    = ff;
        datain       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(S_LD, 1'b1, 1'b0, 8'hA5);
        drive(S_LD, 1'b0, 1'b0, 8'h5A);
        checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout: got %h expected 00", dout); end
        checks++; if (parity_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_parity_done: got %b expected 0", parity_done); end
        checks++; if (low_packet_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_lpv: got %b expected 0", low_packet_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        reset = 1'b0;
    endtask

    // Header 09, payload 11 22, then the given parity byte; correct parity is 3A.
    task automatic test_packet(input string name, input logic [W-1:0] par, input logic exp_err);
        logic e_err;
        e_err = PAR_EN ? exp_err : 1'b0;
        drive(S_DA, 1'b1, 1'b0, 8'h09);
        drive(S_LFD, 1'b1, 1'b0, 8'h11);
        checks++; if (dout !== 8'h09) begin errors++; $display("[TB] FAIL %s_hdr_dout: got %h expected 09", name, dout); end
        drive(S_LD, 1'b1, 1'b0, 8'h11);
        checks++; if (dout !== 8'h11) begin errors++; $display("[TB] FAIL %s_p0_dout: got %h expected 11", name, dout); end
        drive(S_LD, 1'b1, 1'b0, 8'h22);
        checks++; if (dout !== 8'h22) begin errors++; $display("[TB] FAIL %s_p1_dout: got %h expected 22", name, dout); end
        drive(S_LD, 1'b0, 1'b0, par);
        checks++; if (dout !== par) begin errors++; $display("[TB] FAIL %s_par_dout: got %h expected %h", name, dout, par); end
        checks++; if (parity_done !== 1'b1) begin errors++; $display("[TB] FAIL %s_parity_done: got %b expected 1", name, parity_done); end
        checks++; if (low_packet_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s_lpv_set: got %b expected 1", name, low_packet_valid); end
        drive(S_RST, 1'b0, 1'b0, 8'h00);
        checks++; if (err !== e_err) begin errors++; $display("[TB] FAIL %s_err: got %b expected %b", name, err, e_err); end
        checks++; if (low_packet_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s_lpv_clr: got %b expected 0", name, low_packet_valid); end
        drive(S_DA, 1'b1, 1'b0, 8'h09);
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL %s_err_clr: got %b expected 0", name, err); end
        checks++; if (parity_done !== 1'b0) begin errors++; $display("[TB] FAIL %s_pd_clr: got %b expected 0", name, parity_done); end
    endtask

    task automatic test_fifo_full();
        drive(S_DA, 1'b1, 1'b0, 8'h09);
        drive(S_LFD, 1'b1, 1'b0, 8'h11);
        drive(S_LD, 1'b1, 1'b0, 8'h11);
        checks++; if (dout !== 8'h11) begin errors++; $display("[TB] FAIL full_p0_dout: got %h expected 11", dout); end
        drive(S_LD, 1'b1, 1'b1, 8'h22);
        checks++; if (dout !== 8'h11) begin errors++; $display("[TB] FAIL full_hold_dout: got %h expected 11", dout); end
        drive(S_FULL, 1'b1, 1'b1, 8'h55);
        checks++; if (dout !== 8'h11) begin errors++; $display("[TB] FAIL full_state_dout: got %h expected 11", dout); end
        drive(S_LAF, 1'b1, 1'b0, 8'h66);
        checks++; if (dout !== 8'h22) begin errors++; $display("[TB] FAIL full_laf_dout: got %h expected 22", dout); end
        checks++; if (parity_done !== 1'b0) begin errors++; $display("[TB] FAIL full_laf_pd: got %b expected 0", parity_done); end
        drive(S_LD, 1'b0, 1'b0, 8'h3A);
        checks++; if (dout !== 8'h3A) begin errors++; $display("[TB] FAIL full_par_dout: got %h expected 3a", dout); end
        checks++; if (parity_done !== 1'b1) begin errors++; $display("[TB] FAIL full_pd: got %b expected 1", parity_done); end
        drive(S_RST, 1'b0, 1'b0, 8'h00);
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL full_err: got %b expected 0", err); end
    endtask

    // Header 05 (len 1, addr 1), payload 44, parity 41 arrives while the FIFO is full.
    task automatic test_low_pv_during_full();
        drive(S_DA, 1'b1, 1'b0, 8'h05);
        drive(S_LFD, 1'b1, 1'b0, 8'h44);
        checks++; if (dout !== 8'h05) begin errors++; $display("[TB] FAIL lowpv_hdr_dout: got %h expected 05", dout); end
        drive(S_LD, 1'b1, 1'b0, 8'h44);
        drive(S_LD, 1'b0, 1'b1, 8'h41);
        checks++; if (low_packet_valid !== 1'b1) begin errors++; $display("[TB] FAIL lowpv_set: got %b expected 1", low_packet_valid); end
        checks++; if (parity_done !== 1'b0) begin errors++; $display("[TB] FAIL lowpv_pd_early: got %b expected 0", parity_done); end
        checks++; if (dout !== 8'h44) begin errors++; $display("[TB] FAIL lowpv_hold_dout: got %h expected 44", dout); end
        drive(S_FULL, 1'b0, 1'b1, 8'h00);
        checks++; if (parity_done !== 1'b0) begin errors++; $display("[TB] FAIL lowpv_full_pd: got %b expected 0", parity_done); end
        drive(S_LAF, 1'b0, 1'b0, 8'h00);
        checks++; if (parity_done !== 1'b1) begin errors++; $display("[TB] FAIL lowpv_laf_pd: got %b expected 1", parity_done); end
        checks++; if (dout !== 8'h41) begin errors++; $display("[TB] FAIL lowpv_laf_dout: got %h expected 41", dout); end
        drive(S_RST, 1'b0, 1'b0, 8'h00);
        checks++; if (low_packet_valid !== 1'b0) begin errors++; $display("[TB] FAIL lowpv_clr: got %b expected 0", low_packet_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL lowpv_err: got %b expected 0", err); end
        checks++; if (parity_done !== 1'b1) begin errors++; $display("[TB] FAIL lowpv_pd_hold: got %b expected 1", parity_done); end
    endtask

    // Header register still holds 05 from the previous packet.
    task automatic test_invalid_addr();
        drive(S_DA, 1'b1, 1'b0, 8'h0B);
        checks++; if (dout !== 8'h41) begin errors++; $display("[TB] FAIL inv_da_dout: got %h expected 41", dout); end
        drive(S_LFD, 1'b1, 1'b0, 8'h00);
        checks++; if (dout !== 8'h05) begin errors++; $display("[TB] FAIL inv_hdr_kept: got %h expected 05", dout); end
        drive(S_IDLE, 1'b0, 1'b0, 8'h77);
        checks++; if (dout !== 8'h05) begin errors++; $display("[TB] FAIL inv_idle_dout: got %h expected 05", dout); end
    endtask

    // Leave a corrupt packet's flags standing, then reset mid-payload.
    task automatic test_reset_mid();
        drive(S_DA, 1'b1, 1'b0, 8'h09);
        drive(S_LFD, 1'b1, 1'b0, 8'h11);
        drive(S_LD, 1'b1, 1'b0, 8'h11);
        drive(S_LD, 1'b1, 1'b0, 8'h22);
        drive(S_LD, 1'b0, 1'b0, 8'h3B);
        drive(S_RST, 1'b0, 1'b0, 8'h00);
        checks++; if (err !== PAR_EN) begin errors++; $display("[TB] FAIL rstmid_err_pre: got %b expected %b", err, PAR_EN); end
        reset = 1'b1;
        drive(S_LD, 1'b1, 1'b0, 8'h99);
        reset = 1'b0;
        checks++; if (dout !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_dout: got %h expected 00", dout); end
        checks++; if (parity_done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_pd: got %b expected 0", parity_done); end
        checks++; if (low_packet_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_lpv: got %b expected 0", low_packet_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_err: got %b expected 0", err); end
        test_packet("fresh", 8'h3A, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_IDLE;
        packet_valid = 1'b0;
        fifo_full    = 1'b0;
        datain       = '0;
        test_reset();
        test_packet("good", 8'h3A, 1'b0);
        test_packet("corrupt", 8'h3B, 1'b1);
        test_fifo_full();
        test_low_pv_during_full();
        test_invalid_addr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
